fb_scanout: RTL
===============

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH (default 32, BRAM address width), DISPLAY_WIDTH (640, pixels per line), DISPLAY_HEIGHT (480, lines per frame), COLORS (3), COLOR_DEPTH (8), and DATA_WIDTH (COLORS*COLOR_DEPTH, pixel width).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle pulse that begins a frame.
- write_bram  in  1  BRAM half the writer currently fills; the reader uses the other half.
- line_ready  in  1  one-cycle pulse marking that the non-write half holds a complete line.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDR_WIDTH  BRAM read address.
- rd_data  in  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after rd_en.
- pix_data  out  DATA_WIDTH  pixel to display.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  display accepts a pixel.
- pix_sof  out  1  high with the first pixel of a frame.
- pix_eol  out  1  high with the last pixel of each line.
- line_done  out  1  one-cycle pulse; the half just read is released to the writer.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.
- busy  out  1  high when the FSM is not in IDLE.
- underrun  out  1  sticky error flag.

Function
REQ-003 A pixel SHALL transfer only in a cycle where pix_valid=1 and pix_ready=1.
REQ-004 While pix_valid=1 and pix_ready=0, pix_data, pix_sof and pix_eol SHALL hold stable.
REQ-005 The FSM SHALL have four states: IDLE, WAIT_LINE, STREAM, DRAIN.
REQ-006 IDLE: on start, the FSM SHALL go to WAIT_LINE, clear y to 0 and clear underrun; start in any other state SHALL be ignored.
REQ-007 line_pending SHALL set on line_ready and clear when WAIT_LINE leaves for STREAM. If both happen in the same cycle, line_pending SHALL stay 1. A line_ready while line_pending=1 SHALL be dropped.
REQ-008 WAIT_LINE: when line_pending=1, the FSM SHALL go to STREAM, latch base = (write_bram ? 0 : DISPLAY_WIDTH), and clear x to 0.
REQ-009 STREAM: on each cycle where the FSM issues a read, rd_en=1, rd_addr=base+x and x increments. After the read with x=DISPLAY_WIDTH-1, the FSM SHALL go to DRAIN.
REQ-010 rd_data SHALL land in a 2-entry output FIFO that drives pix_*. The FSM SHALL issue a read only if (FIFO occupancy + reads in flight) < 2. The FIFO SHALL never overflow.
REQ-011 With pix_ready held at 1, throughput SHALL be 1 pixel/cycle. The first pixel of a line SHALL appear 2 cycles after the FSM enters STREAM.
REQ-012 pix_eol SHALL accompany the x=DISPLAY_WIDTH-1 pixel. pix_sof SHALL accompany x=0 of y=0.
REQ-013 DRAIN: when the eol pixel is accepted, line_done SHALL pulse for 1 cycle. Then:
- if y=DISPLAY_HEIGHT-1, frame_done SHALL pulse for 1 cycle and the FSM goes to IDLE;
- otherwise y increments and the FSM goes to WAIT_LINE.
REQ-014 underrun SHALL set when the FSM is in WAIT_LINE with y≠0 and pix_ready=1. It SHALL stay set until start or rst.
REQ-015 The rd_en=0 value of rd_addr SHALL be don't-care. rd_addr SHALL be computed at ADDR_WIDTH, and base+x SHALL never exceed 2*DISPLAY_WIDTH-1.

Reset
REQ-016 When rst=1, asynchronously and without waiting for clk:
- the FSM SHALL go to IDLE;
- x, y, base, line_pending, the FIFO and in-flight tracking SHALL clear;
- rd_en, pix_valid, pix_sof, pix_eol, line_done, frame_done, busy and underrun SHALL be 0;
- pix_data and rd_addr SHALL be 0.
REQ-017 Reset mid-line SHALL discard all buffered and in-flight data. No line_done or frame_done pulse SHALL be emitted for the aborted line.

Verification (bench parameters DISPLAY_WIDTH=4, DISPLAY_HEIGHT=2, BRAM preloaded with addr i holding data i)
REQ-018 Sequence start, write_bram=1, line_ready, with pix_ready=1 -> rd_addr 0,1,2,3 on consecutive cycles; pix_data 0..3; pix_sof with 0; pix_eol with 3; one line_done.
REQ-019 Second line with write_bram=0 and line_ready -> rd_addr 4..7; pix_data 4..7; line_done, then frame_done the following cycle; busy falls to 0.
REQ-020 pix_ready toggled 1,0,0,1,... during a line -> pix_data holds while stalled; no pixel lost or duplicated; rd_en never issues with 2 entries outstanding.
REQ-021 pix_ready=1 held in WAIT_LINE before the second line_ready -> underrun=1 and remains 1 through frame_done; the next start clears it.
REQ-022 rst asserted after 2 pixels, then start and line_ready -> all outputs 0 during rst; the new frame restarts with pix_sof on pixel 0; no line_done for the aborted line.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Scan-out bus bundle: BRAM read port plus the outgoing pixel stream.
//
// Handshake: the pixel stream is strict valid/ready. A pixel moves only in a
// cycle where pix_valid and pix_ready are both 1. Once pix_valid is raised,
// pix_data, pix_sof and pix_eol hold stable until that transfer happens, and
// the source never withdraws pix_valid without a transfer. The BRAM port is
// not handshaked: rd_data is valid exactly one cycle after rd_en.
interface fb_scanout_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 24
) ();
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;

  // Scan-out engine side.
  modport master (
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    input  rd_data, pix_ready
  );

  // BRAM and display side.
  modport slave (
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: reads one ping-pong BRAM half per line and streams
// the pixels to the display through a 2-entry output FIFO, tagging the first
// pixel of the frame (sof) and the last pixel of each line (eol).
module fb_scanout #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int COLORS         = 3,
  parameter int COLOR_DEPTH    = 8,
  parameter int DATA_WIDTH     = COLORS * COLOR_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         write_bram,
  input  logic         line_ready,
  fb_scanout_if.master bus,
  output logic         line_done,
  output logic         frame_done,
  output logic         busy,
  output logic         underrun
);

  localparam int XW = $clog2(DISPLAY_WIDTH + 1);
  localparam int YW = $clog2(DISPLAY_HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(DISPLAY_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(DISPLAY_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] base;
  logic                  line_pending;
  logic                  frame_end;

  // Read pipeline: tags travel alongside the read so they meet rd_data.
  logic                  rd_vld;
  logic                  rd_sof_q;
  logic                  rd_eol_q;

  // Output FIFO.
  entry_t                mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  issue;
  logic                  pop;
  logic                  push;
  logic [2:0]            outstanding;
  entry_t                head;

  // Issue decision. It counts this cycle's pop as freeing a slot, which is
  // what lets a 2-entry FIFO sustain one pixel per cycle across the
  // one-cycle BRAM latency while still never overflowing.
  always_comb begin
    head        = mem[rd_ptr];
    pop         = (count != 2'd0) && bus.pix_ready;
    push        = rd_vld;
    outstanding = {1'b0, count} + {2'b00, rd_vld} - {2'b00, pop};
    issue       = (state == STREAM) && (outstanding < 3'd2);
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = base + ADDR_WIDTH'(x);
  assign bus.pix_valid = (count != 2'd0);
  assign bus.pix_data  = head.data;
  assign bus.pix_sof   = head.sof & bus.pix_valid;
  assign bus.pix_eol   = head.eol & bus.pix_valid;
  assign busy          = (state != IDLE);

  // Line/frame sequencing FSM with its counters, flags and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      base         <= '0;
      line_pending <= 1'b0;
      frame_end    <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;

      // A new line_ready wins over the clear when both land together.
      if (line_ready) begin
        line_pending <= 1'b1;
      end else if (state == WAIT_LINE && line_pending) begin
        line_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT_LINE;
            y        <= '0;
            underrun <= 1'b0;
          end
        end
        WAIT_LINE: begin
          // The display wants pixels mid-frame but no line is ready yet.
          if (y != '0 && bus.pix_ready) begin
            underrun <= 1'b1;
          end
          if (line_pending) begin
            state <= STREAM;
            base  <= write_bram ? '0 : ADDR_WIDTH'(DISPLAY_WIDTH);
            x     <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            if (x == X_LAST) begin
              state <= DRAIN;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (frame_end) begin
            frame_end  <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (pop && head.eol) begin
            line_done <= 1'b1;
            if (y == Y_LAST) begin
              frame_end <= 1'b1;
            end else begin
              y     <= y + 1'b1;
              state <= WAIT_LINE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read in flight and the sof/eol tags that belong to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_sof_q <= 1'b0;
      rd_eol_q <= 1'b0;
    end else begin
      rd_vld   <= issue;
      rd_sof_q <= (x == '0) && (y == '0);
      rd_eol_q <= (x == X_LAST);
    end
  end

  // Output FIFO: push returning BRAM data, pop on an accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{sof: rd_sof_q, eol: rd_eol_q, data: bus.rd_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
